// File: rtl/control_pkg.sv
// control_pkg: shared constants and types for the multicycle control unit.
package control_pkg;
    typedef enum logic [2:0] {S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_NOP, C_ALU, C_LOAD, C_STORE, C_B, C_BEQ, C_BNE} iclass_t;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 26;
    localparam int FUNC_HI = 3;
    localparam int FUNC_LO = 0;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b010000;
    localparam logic [5:0] OP_BNE   = 6'b010001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NOT  = 4'b0100;
    localparam logic [3:0] ALU_NAND = 4'b0101;
    localparam logic [3:0] ALU_NOR  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_ROL  = 4'b1100;
    localparam logic [3:0] ALU_ROR  = 4'b1101;
endpackage

// File: rtl/control_if.sv
// control_if: control-unit <-> datapath signal bundle.
interface control_if;
    logic [31:0] Instr;
    logic        ALU_zero;
    logic        PC_Sel;
    logic        PC_LdEn;
    logic        Reset;
    logic        RF_B_sel;
    logic        RF_WrData_sel;
    logic        RF_WEn;
    logic        ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        MEM_WrEn;

    modport master (
        input  Instr, ALU_zero,
        output PC_Sel, PC_LdEn, Reset, RF_B_sel, RF_WrData_sel, RF_WEn, ALU_Bin_sel, ALU_func, MEM_WrEn
    );
    modport slave (
        output Instr, ALU_zero,
        input  PC_Sel, PC_LdEn, Reset, RF_B_sel, RF_WrData_sel, RF_WEn, ALU_Bin_sel, ALU_func, MEM_WrEn
    );
endinterface

// File: rtl/control_decode.sv
// control_decode: maps IR opcode/func to instruction class, ALU function and static selects.
module control_decode
    import control_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [3:0] func_i,
    output iclass_t    cls_o,
    output logic [3:0] alu_func_o,
    output logic       alu_bin_sel_o,
    output logic       rf_b_sel_o,
    output logic       rf_wrdata_sel_o
);
    always_comb begin
        cls_o           = C_NOP;
        alu_func_o      = ALU_ADD;
        alu_bin_sel_o   = 1'b0;
        rf_b_sel_o      = 1'b0;
        rf_wrdata_sel_o = 1'b0;
        case (opcode_i)
            OP_RTYPE: begin
                cls_o      = C_ALU;
                alu_func_o = func_i;
            end
            OP_LI, OP_LUI, OP_ADDI: begin
                cls_o         = C_ALU;
                alu_bin_sel_o = 1'b1;
            end
            OP_ANDI: begin
                cls_o         = C_ALU;
                alu_func_o    = ALU_AND;
                alu_bin_sel_o = 1'b1;
            end
            OP_ORI: begin
                cls_o         = C_ALU;
                alu_func_o    = ALU_OR;
                alu_bin_sel_o = 1'b1;
            end
            OP_LB, OP_LW: begin
                cls_o           = C_LOAD;
                alu_bin_sel_o   = 1'b1;
                rf_wrdata_sel_o = 1'b1;
            end
            OP_SB, OP_SW: begin
                cls_o         = C_STORE;
                alu_bin_sel_o = 1'b1;
                rf_b_sel_o    = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                cls_o      = (opcode_i == OP_BEQ) ? C_BEQ : C_BNE;
                alu_func_o = ALU_SUB;
                rf_b_sel_o = 1'b1;
            end
            OP_B: cls_o = C_B;
            default: cls_o = C_NOP;
        endcase
    end
endmodule

// File: rtl/control.sv
// control: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath selects and enables.
// Enables are decoded from the state register, so an async reset drops them immediately.
module control
    import control_pkg::*;
(
    input  logic     Clk,
    input  logic     Reset_n,
    control_if.master bus
);
    state_t     state_q, state_d;
    logic [5:0] op_q;
    logic [3:0] fn_q;
    iclass_t    cls;
    logic [3:0] alu_func;
    logic       alu_bin_sel, rf_b_sel, rf_wrdata_sel, live;

    control_decode u_decode (
        .opcode_i        (op_q),
        .func_i          (fn_q),
        .cls_o           (cls),
        .alu_func_o      (alu_func),
        .alu_bin_sel_o   (alu_bin_sel),
        .rf_b_sel_o      (rf_b_sel),
        .rf_wrdata_sel_o (rf_wrdata_sel)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_RST;
            op_q    <= '0;
            fn_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                op_q <= bus.Instr[OPC_HI:OPC_LO];
                fn_q <= bus.Instr[FUNC_HI:FUNC_LO];
            end
        end
    end

    // selects stay valid from DECODE until the instruction retires
    assign live = (state_q == S_DECODE) || (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

    always_comb begin
        state_d           = state_q;
        bus.Reset         = 1'b0;
        bus.PC_Sel        = 1'b0;
        bus.PC_LdEn       = 1'b0;
        bus.RF_WEn        = 1'b0;
        bus.MEM_WrEn      = 1'b0;
        bus.RF_B_sel      = live ? rf_b_sel : 1'b0;
        bus.RF_WrData_sel = live ? rf_wrdata_sel : 1'b0;
        bus.ALU_Bin_sel   = live ? alu_bin_sel : 1'b0;
        bus.ALU_func      = live ? alu_func : ALU_ADD;
        case (state_q)
            S_RST: begin
                bus.Reset = 1'b1;
                state_d   = S_FETCH;
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if (cls == C_ALU) state_d = S_WB;
                else if (cls == C_LOAD || cls == C_STORE) state_d = S_MEM;
                else begin
                    bus.PC_LdEn = 1'b1;
                    bus.PC_Sel  = (cls == C_B) || (cls == C_BEQ && bus.ALU_zero) || (cls == C_BNE && !bus.ALU_zero);
                    state_d     = S_FETCH;
                end
            end
            S_MEM: begin
                if (cls == C_STORE) begin
                    bus.MEM_WrEn = 1'b1;
                    bus.PC_LdEn  = 1'b1;
                    state_d      = S_FETCH;
                end else state_d = S_WB;
            end
            S_WB: begin
                bus.RF_WEn  = 1'b1;
                bus.PC_LdEn = 1'b1;
                state_d     = S_FETCH;
            end
            default: state_d = S_RST;
        endcase
    end
endmodule

// File: tb/tb_control.sv
// tb_control: directed + random instruction sequences checked cycle by cycle against a per-instruction model.
module tb_control;
    logic clk, rst_n;
    int   tests = 0;
    int   fails = 0;

    control_if bus ();
    control dut (.Clk(clk), .Reset_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // vector: {PC_Sel, PC_LdEn, Reset, RF_B_sel, RF_WrData_sel, RF_WEn, ALU_Bin_sel, ALU_func[3:0], MEM_WrEn}
    function automatic logic [11:0] obs();
        return {bus.PC_Sel, bus.PC_LdEn, bus.Reset, bus.RF_B_sel, bus.RF_WrData_sel, bus.RF_WEn,
                bus.ALU_Bin_sel, bus.ALU_func, bus.MEM_WrEn};
    endfunction

    task automatic chk(input string tag, input logic [11:0] o, input logic [11:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%03h expected=%03h", tag, o, e);
        end
    endtask

    // instruction-level model: class -> cycle count, static settings, and what fires in the last cycle
    typedef struct {
        int         n;
        logic [3:0] afn;
        logic       bin, bsel, wd, wr, st, tk;
    } info_t;

    function automatic info_t model(input logic [31:0] i, input logic z);
        info_t m;
        m = '{n: 3, afn: 4'h0, bin: 0, bsel: 0, wd: 0, wr: 0, st: 0, tk: 0};
        case (i[31:26])
            6'b100000: begin m.afn = i[3:0]; m.wr = 1; end
            6'b111000, 6'b111001, 6'b110000: begin m.bin = 1; m.wr = 1; end
            6'b110010: begin m.afn = 4'h2; m.bin = 1; m.wr = 1; end
            6'b110011: begin m.afn = 4'h3; m.bin = 1; m.wr = 1; end
            6'b000011, 6'b001111: begin m.bin = 1; m.wd = 1; m.wr = 1; m.n = 5; end
            6'b000111, 6'b011111: begin m.bin = 1; m.bsel = 1; m.st = 1; end
            6'b010000: begin m.afn = 4'h1; m.bsel = 1; m.tk = z; end
            6'b010001: begin m.afn = 4'h1; m.bsel = 1; m.tk = !z; end
            6'b111111: m.tk = 1;
            default: ;
        endcase
        if (m.n != 5 && (m.wr || m.st)) m.n = 4;
        return m;
    endfunction

    function automatic logic [11:0] expv(input info_t m, input int k);
        logic last;
        last = (k == m.n);
        if (k == 1) return 12'h000;
        return {last & m.tk, last, 1'b0, m.bsel, m.wd, last & m.wr, m.bin, m.afn, last & m.st};
    endfunction

    // runs one instruction; optionally asserts reset asynchronously in cycle abort_k
    task automatic run(input logic [31:0] i, input logic z, input string tag, input int abort_k = 0);
        info_t m;
        m = model(i, z);
        for (int k = 1; k <= m.n; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.Instr    = i;
                bus.ALU_zero = z;
            end
            chk($sformatf("%s_c%0d", tag, k), obs(), expv(m, k));
            if (k > 1) bus.Instr = $urandom;
            if (k == abort_k) begin
                #1 rst_n = 1'b0;
                #1 chk($sformatf("%s_async_rst", tag), obs(), 12'h200);
                @(negedge clk);
                chk($sformatf("%s_rst_hold", tag), obs(), 12'h200);
                rst_n = 1'b1;
                return;
            end
        end
    endtask

    logic [5:0] ops [13] = '{6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011,
                             6'b111111, 6'b010000, 6'b010001, 6'b000011, 6'b000111, 6'b001111, 6'b011111};

    initial begin
        logic [31:0] ri;
        rst_n        = 1'b0;
        bus.Instr    = 32'h0;
        bus.ALU_zero = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("reset_c%0d", c), obs(), 12'h200);
        end
        rst_n = 1'b1;
        run(32'h80221801, 1'b0, "rsub");
        run(32'hC0220005, 1'b0, "addi");
        run(32'h3C220004, 1'b0, "lw");
        run(32'h7C220004, 1'b0, "sw");
        run(32'h40220003, 1'b1, "beq_t");
        run(32'h40220003, 1'b0, "beq_nt");
        run(32'h44220003, 1'b1, "bne_nt");
        run(32'h44220003, 1'b0, "bne_t");
        run(32'hFC000010, 1'b0, "b");
        run(32'h00000000, 1'b1, "nop");
        run(32'h7C220004, 1'b0, "sw_abort", 4);
        run(32'h0C220004, 1'b0, "lb");
        run(32'h1C220004, 1'b1, "sb");
        for (int t = 0; t < 300; t++) begin
            ri = $urandom;
            if ($urandom_range(0, 4) != 0) ri[31:26] = ops[$urandom_range(0, 12)];
            run(ri, 1'($urandom_range(0, 1)), $sformatf("rnd%0d_%08h", t, ri));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
